reg_file_bank: RTL and testbench
================================

Name: reg_file_bank

Overview:
- Register storage bank directly downstream of the AXI4-lite register slave.
- Consumes per-register bus write requests and returns all register values as read data over ifc_reg_file_direct_access.
- Merges hardware-side updates (full-word writes and sticky event flags) with bus writes using a fixed per-bit priority.
- Exports current values, write pulses and a collision counter to the user logic.

Parameters:
- NUM_REGISTERS, 16: number of registers; must equal REG_FILE_NUM_REGISTERS.
- REGISTER_WIDTH, 32: bits per register.
- COLLISION_CNT_WIDTH, 16: width of the saturating collision counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- if_reg_file  ifc_reg_file_direct_access.slave  -  write_req[N], write_data[N][W] in; read_data[N][W] out.
- i_hw_write_req  in  NUM_REGISTERS  per-register hardware write strobe.
- i_hw_write_data  in  NUM_REGISTERS x REGISTER_WIDTH  hardware write data.
- i_hw_event  in  NUM_REGISTERS x REGISTER_WIDTH  per-bit sticky set pulses.
- o_reg_value  out  NUM_REGISTERS x REGISTER_WIDTH  current register contents.
- o_bus_write_pulse  out  NUM_REGISTERS  1-cycle pulse when a bus write has landed.
- o_collision_count  out  COLLISION_CNT_WIDTH  saturating count of bus/hardware write collisions.

Behaviour:
- Interface decision: one clock, clk; reset is synchronous and active-high on rst.
- Reset: value[i] = REG_FILE_RESET_VALUE[i]; o_bus_write_pulse = 0; o_collision_count = 0. read_data and o_reg_value reflect the reset values from the first cycle after reset.
- Masks per register, from the package: BUS_WMASK[i] (bus-writable bits), HW_WMASK[i] (hardware-writable bits), EVENT_MASK[i] (sticky event bits).
- Per-bit next-value priority, evaluated every cycle:
  1. i_hw_event[i][b] & EVENT_MASK[i][b] -> 1.
  2. i_hw_write_req[i] & HW_WMASK[i][b] -> i_hw_write_data[i][b].
  3. write_req[i] & BUS_WMASK[i][b] -> write_data[i][b].
  4. Otherwise hold.
- Rule 1 beats rule 3: an event arriving in the same cycle as a bus clear (including the slave's clear-on-read zero write) sets the bit, so no event is lost.
- Bits outside every mask stay at their reset value forever.
- Latency:
  - A write presented at edge n is visible on read_data/o_reg_value after edge n (registered, 1 cycle).
  - read_data is a combinational copy of the storage; no extra register.
- o_bus_write_pulse[i] is registered: high for exactly one cycle after any cycle with write_req[i] = 1, even if all bits were masked off.
- Collision: write_req[i] & i_hw_write_req[i] & |(BUS_WMASK[i] & HW_WMASK[i]) for any i.
  - The counter increments by 1 per cycle in which a collision occurs, however many registers collide.
  - It saturates at all-ones and never wraps.
  - Only rst clears it.
- Reset mid-operation: rst has priority over every request in the same cycle. Requests present during rst are dropped and produce no pulse and no count.
- Out-of-range IDs cannot occur; the bus side is per-register one-hot.

Decomposition:
- Additions to reg_file_pkg:
  - REG_FILE_RESET_VALUE, REG_FILE_BUS_WMASK, REG_FILE_HW_WMASK, REG_FILE_EVENT_MASK: constant arrays indexed by reg_file_id_t, width REGISTER_WIDTH.
  - reg_value_t typedef.
- Sub-module reg_file_cell: one register holding the priority merge and its write pulse, instantiated NUM_REGISTERS times in a generate loop.
- The collision counter lives in the top level.

Test Plan:
- Reset, then read all registers -> every read_data[i] equals REG_FILE_RESET_VALUE[i]; o_collision_count = 0; no pulses.
- Bus write 0xFFFF_FFFF to reg 2 with BUS_WMASK = 0x0000_00FF -> next cycle value = reset value with bits 7:0 = 0xFF; o_bus_write_pulse[2] high for exactly 1 cycle.
- Reg 3 (EVENT_MASK = 0x1) holds 1; in the same cycle i_hw_event[3][0] = 1 and a bus write of 0 (clear-on-read) -> value stays 0x1, pulse[3] = 1.
- Same-cycle bus write 0xAAAA_AAAA and hw write 0x5555_5555 to reg 4, both masks 0xFFFF_FFFF -> value = 0x5555_5555; o_collision_count = 1.
- Force collisions for 2^COLLISION_CNT_WIDTH + 5 cycles -> o_collision_count holds 0xFFFF and does not wrap.
- Assert rst while bus and hw requests are active -> values return to reset constants, no pulse, count = 0 on the next cycle.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Register file constants: geometry, per-register reset values and write/event masks.
package reg_file_pkg;

  localparam int REG_FILE_NUM_REGISTERS  = 16;
  localparam int REG_FILE_REGISTER_WIDTH = 32;

  typedef logic [$clog2(REG_FILE_NUM_REGISTERS)-1:0] reg_file_id_t;
  typedef logic [REG_FILE_REGISTER_WIDTH-1:0]        reg_value_t;

  localparam reg_value_t REG_FILE_RESET_VALUE [REG_FILE_NUM_REGISTERS] = '{
    32'h0000_0000, 32'h1234_5678, 32'hA5A5_0000, 32'h0000_0000,
    32'h0000_0000, 32'hDEAD_0000, 32'h0000_0000, 32'h0000_0000,
    32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
    32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h8000_0001
  };

  localparam reg_value_t REG_FILE_BUS_WMASK [REG_FILE_NUM_REGISTERS] = '{
    32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_00FF, 32'h0000_00FF,
    32'hFFFF_FFFF, 32'h0000_FFFF, 32'h0000_00FF, 32'hFFFF_FFFF,
    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF
  };

  localparam reg_value_t REG_FILE_HW_WMASK [REG_FILE_NUM_REGISTERS] = '{
    32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
    32'hFFFF_FFFF, 32'hFFFF_0000, 32'h0000_0F0F, 32'h0000_0000,
    32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
    32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000
  };

  localparam reg_value_t REG_FILE_EVENT_MASK [REG_FILE_NUM_REGISTERS] = '{
    32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001,
    32'h0000_0000, 32'h0000_0000, 32'h0000_F000, 32'h0000_0000,
    32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
    32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000
  };

endpackage

// File: rtl/ifc_reg_file_direct_access.sv
// Per-register write requests from the bus slave and the full read-back image.
interface ifc_reg_file_direct_access #(
  parameter int NUM_REGISTERS  = 16,
  parameter int REGISTER_WIDTH = 32
);
  logic [NUM_REGISTERS-1:0]                     write_req;
  logic [NUM_REGISTERS-1:0][REGISTER_WIDTH-1:0] write_data;
  logic [NUM_REGISTERS-1:0][REGISTER_WIDTH-1:0] read_data;

  modport master (output write_req, output write_data, input  read_data);
  modport slave  (input  write_req, input  write_data, output read_data);
endinterface

// File: rtl/reg_file_cell.sv
// One register: merges event, hardware and bus writes per bit, and flags landed bus writes.
module reg_file_cell #(
  parameter int                        REGISTER_WIDTH = 32,
  parameter logic [REGISTER_WIDTH-1:0] RESET_VALUE    = '0,
  parameter logic [REGISTER_WIDTH-1:0] BUS_WMASK      = '0,
  parameter logic [REGISTER_WIDTH-1:0] HW_WMASK       = '0,
  parameter logic [REGISTER_WIDTH-1:0] EVENT_MASK     = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      bus_write_req,
  input  logic [REGISTER_WIDTH-1:0] bus_write_data,
  input  logic                      hw_write_req,
  input  logic [REGISTER_WIDTH-1:0] hw_write_data,
  input  logic [REGISTER_WIDTH-1:0] hw_event,
  output logic [REGISTER_WIDTH-1:0] value,
  output logic                      bus_write_pulse
);

  logic [REGISTER_WIDTH-1:0] value_next;

  // Lowest priority is applied first so each later stage overrides it bit by bit.
  always_comb begin
    // NOTE: the hold default comes first so every path assigns value_next; no latch.
    value_next = value;
    if (bus_write_req) value_next = (value_next & ~BUS_WMASK) | (bus_write_data & BUS_WMASK);
    if (hw_write_req)  value_next = (value_next & ~HW_WMASK)  | (hw_write_data  & HW_WMASK);
    value_next = value_next | (hw_event & EVENT_MASK);
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values together.
  always_ff @(posedge clk) begin
    if (rst) begin
      value           <= RESET_VALUE;
      bus_write_pulse <= 1'b0;
    end else begin
      value           <= value_next;
      bus_write_pulse <= bus_write_req;
    end
  end

endmodule

// File: rtl/reg_file_bank.sv
// Register storage bank behind the bus slave: per-register cells plus a collision counter.
module reg_file_bank
  import reg_file_pkg::*;
#(
  parameter int NUM_REGISTERS       = REG_FILE_NUM_REGISTERS,
  parameter int REGISTER_WIDTH      = REG_FILE_REGISTER_WIDTH,
  parameter int COLLISION_CNT_WIDTH = 16
) (
  input  logic                                         clk,
  input  logic                                         rst,
  ifc_reg_file_direct_access.slave                     if_reg_file,
  input  logic [NUM_REGISTERS-1:0]                     i_hw_write_req,
  input  logic [NUM_REGISTERS-1:0][REGISTER_WIDTH-1:0] i_hw_write_data,
  input  logic [NUM_REGISTERS-1:0][REGISTER_WIDTH-1:0] i_hw_event,
  output logic [NUM_REGISTERS-1:0][REGISTER_WIDTH-1:0] o_reg_value,
  output logic [NUM_REGISTERS-1:0]                     o_bus_write_pulse,
  output logic [COLLISION_CNT_WIDTH-1:0]               o_collision_count
);

  localparam logic [COLLISION_CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [NUM_REGISTERS-1:0] mask_overlap;
  logic                     collision;

  // NOTE: every register is an individual flop with its own reset constant, not a RAM,
  // so resetting the whole bank is both legal and required here.
  for (genvar i = 0; i < NUM_REGISTERS; i++) begin : g_cell
    localparam reg_file_id_t ID = reg_file_id_t'(i);

    reg_file_cell #(
      .REGISTER_WIDTH (REGISTER_WIDTH),
      .RESET_VALUE    (REGISTER_WIDTH'(REG_FILE_RESET_VALUE[ID])),
      .BUS_WMASK      (REGISTER_WIDTH'(REG_FILE_BUS_WMASK[ID])),
      .HW_WMASK       (REGISTER_WIDTH'(REG_FILE_HW_WMASK[ID])),
      .EVENT_MASK     (REGISTER_WIDTH'(REG_FILE_EVENT_MASK[ID]))
    ) u_cell (
      .clk             (clk),
      .rst             (rst),
      .bus_write_req   (if_reg_file.write_req[i]),
      .bus_write_data  (if_reg_file.write_data[i]),
      .hw_write_req    (i_hw_write_req[i]),
      .hw_write_data   (i_hw_write_data[i]),
      .hw_event        (i_hw_event[i]),
      .value           (o_reg_value[i]),
      .bus_write_pulse (o_bus_write_pulse[i])
    );

    // Constant per register: a collision needs at least one bit both sides may write.
    assign mask_overlap[i] = |(REG_FILE_BUS_WMASK[ID] & REG_FILE_HW_WMASK[ID]);
  end

  assign if_reg_file.read_data = o_reg_value;

  // One count per cycle regardless of how many registers collide.
  assign collision = |(if_reg_file.write_req & i_hw_write_req & mask_overlap);

  always_ff @(posedge clk) begin
    if (rst) begin
      o_collision_count <= '0;
    end else if (collision && (o_collision_count != CNT_MAX)) begin
      o_collision_count <= o_collision_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_file_bank.sv
// Directed, table-driven bench for reg_file_bank with hand-computed expectations.
module tb_reg_file_bank;

  localparam int N  = 16;
  localparam int W  = 32;
  localparam int CW = 16;

  typedef struct {
    int          id;
    bit          bus_req;
    logic [31:0] bus_data;
    bit          hw_req;
    logic [31:0] hw_data;
    logic [31:0] evt;
    logic [31:0] exp_value;
    bit          exp_pulse;
    bit          collide;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]         hw_req;
  logic [N-1:0][W-1:0]  hw_data;
  logic [N-1:0][W-1:0]  hw_event;
  logic [N-1:0][W-1:0]  reg_value;
  logic [N-1:0]         bus_pulse;
  logic [CW-1:0]        coll_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt;

  ifc_reg_file_direct_access #(.NUM_REGISTERS(N), .REGISTER_WIDTH(W)) bus_if ();

  reg_file_bank #(.NUM_REGISTERS(N), .REGISTER_WIDTH(W), .COLLISION_CNT_WIDTH(CW)) dut (
    .clk               (clk),
    .rst               (rst),
    .if_reg_file       (bus_if),
    .i_hw_write_req    (hw_req),
    .i_hw_write_data   (hw_data),
    .i_hw_event        (hw_event),
    .o_reg_value       (reg_value),
    .o_bus_write_pulse (bus_pulse),
    .o_collision_count (coll_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.write_req  = '0;
    bus_if.write_data = '0;
    hw_req            = '0;
    hw_data           = '0;
    hw_event          = '0;
  endtask

  logic [31:0] rst_val [N];
  vec_t        vecs    [13];

  initial begin
    rst_val = '{32'h0000_0000, 32'h1234_5678, 32'hA5A5_0000, 32'h0000_0000,
                32'h0000_0000, 32'hDEAD_0000, 32'h0000_0000, 32'h0000_0000,
                32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
                32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h8000_0001};

    //          id bus data          hw data          evt              expected        pulse coll
    vecs[0]  = '{0,  1, 32'hCAFE_F00D, 0, 32'h0,         32'h0,         32'hCAFE_F00D, 1, 0};
    vecs[1]  = '{1,  1, 32'hFFFF_FFFF, 0, 32'h0,         32'h0,         32'h1234_5678, 1, 0};
    vecs[2]  = '{2,  1, 32'hFFFF_FFFF, 0, 32'h0,         32'h0,         32'hA5A5_00FF, 1, 0};
    vecs[3]  = '{3,  0, 32'h0,         0, 32'h0,         32'h0000_0001, 32'h0000_0001, 0, 0};
    vecs[4]  = '{3,  1, 32'h0,         0, 32'h0,         32'h0000_0001, 32'h0000_0001, 1, 0};
    vecs[5]  = '{3,  1, 32'h0,         0, 32'h0,         32'h0,         32'h0000_0000, 1, 0};
    vecs[6]  = '{3,  0, 32'h0,         0, 32'h0,         32'hFFFF_FFFF, 32'h0000_0001, 0, 0};
    vecs[7]  = '{4,  1, 32'hAAAA_AAAA, 1, 32'h5555_5555, 32'h0,         32'h5555_5555, 1, 1};
    vecs[8]  = '{5,  1, 32'h0000_BEEF, 1, 32'h1234_FFFF, 32'h0,         32'h1234_BEEF, 1, 0};
    vecs[9]  = '{6,  1, 32'hFFFF_FFFF, 1, 32'h0,         32'h0000_F000, 32'h0000_F0F0, 1, 1};
    vecs[10] = '{4,  0, 32'h0,         1, 32'h0F0F_0F0F, 32'h0,         32'h0F0F_0F0F, 0, 0};
    vecs[11] = '{0,  1, 32'h0,         1, 32'hFFFF_FFFF, 32'h0,         32'h0000_0000, 1, 0};
    vecs[12] = '{15, 1, 32'h0,         0, 32'h0,         32'h0,         32'h8000_0000, 1, 0};

    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    for (int i = 0; i < N; i++) begin
      check($sformatf("reset read_data[%0d]", i), 64'(bus_if.read_data[i]), 64'(rst_val[i]));
      check($sformatf("reset reg_value[%0d]", i), 64'(reg_value[i]), 64'(rst_val[i]));
    end
    check("reset pulses", 64'(bus_pulse), 64'(0));
    check("reset count", 64'(coll_cnt), 64'(0));

    exp_cnt = 0;
    for (int v = 0; v < 13; v++) begin
      idle_inputs();
      bus_if.write_req[vecs[v].id]  = vecs[v].bus_req;
      bus_if.write_data[vecs[v].id] = vecs[v].bus_data;
      hw_req[vecs[v].id]            = vecs[v].hw_req;
      hw_data[vecs[v].id]           = vecs[v].hw_data;
      hw_event[vecs[v].id]          = vecs[v].evt;
      tick();
      if (vecs[v].collide) exp_cnt++;
      check($sformatf("vec%0d value", v), 64'(reg_value[vecs[v].id]), 64'(vecs[v].exp_value));
      check($sformatf("vec%0d read_data", v), 64'(bus_if.read_data[vecs[v].id]), 64'(vecs[v].exp_value));
      check($sformatf("vec%0d pulse", v), 64'(bus_pulse), 64'(N'(vecs[v].exp_pulse) << vecs[v].id));
      check($sformatf("vec%0d count", v), 64'(coll_cnt), 64'(exp_cnt));
    end

    // Pulse must drop after a single cycle once requests stop.
    idle_inputs();
    tick();
    check("pulse single cycle", 64'(bus_pulse), 64'(0));
    check("value held reg0", 64'(reg_value[0]), 64'(0));

    // Two registers colliding in one cycle count once.
    bus_if.write_req[4] = 1'b1;
    hw_req[4]           = 1'b1;
    bus_if.write_req[6] = 1'b1;
    hw_req[6]           = 1'b1;
    tick();
    check("multi collision count", 64'(coll_cnt), 64'(3));

    // Saturation: 65532 more collision cycles reach all-ones, further ones must not wrap.
    idle_inputs();
    bus_if.write_req[4] = 1'b1;
    hw_req[4]           = 1'b1;
    repeat (65532) tick();
    check("count reaches max", 64'(coll_cnt), 64'(16'hFFFF));
    repeat (8) tick();
    check("count saturated", 64'(coll_cnt), 64'(16'hFFFF));

    // Reset wins over simultaneous bus, hardware and event requests.
    bus_if.write_req[0]  = 1'b1;
    bus_if.write_data[0] = 32'h1111_1111;
    hw_data[4]           = 32'h2222_2222;
    bus_if.write_data[4] = 32'h3333_3333;
    hw_event[3]          = 32'h0000_0001;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    check("rst reg0", 64'(reg_value[0]), 64'(rst_val[0]));
    check("rst reg3", 64'(reg_value[3]), 64'(rst_val[3]));
    check("rst reg4", 64'(reg_value[4]), 64'(rst_val[4]));
    check("rst reg15", 64'(reg_value[15]), 64'(rst_val[15]));
    check("rst pulses", 64'(bus_pulse), 64'(0));
    check("rst count", 64'(coll_cnt), 64'(0));
    tick();
    check("post rst pulses", 64'(bus_pulse), 64'(0));
    check("post rst count", 64'(coll_cnt), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
